// File: rtl/wb_stage_pipe.sv
// Write-back stage: selects ALU/memory result, applies load extension, buffers up to two register writes.
// Latency 1 cycle from accept to rf_wen when empty; in_ready drops at two pending writes, no pass-through.
module wb_stage_pipe #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wen,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_sel,
  input  logic [1:0]        in_ld_mode,
  input  logic [DATA_W-1:0] in_ans_alu,
  input  logic [DATA_W-1:0] in_ans_dm,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic              rf_ready,
  input  logic [ADDR_W-1:0] fwd_rd,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retire_count
);

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] dat;
  } wb_ent_t;

  wb_ent_t           head_q;
  wb_ent_t           tail_q;
  wb_ent_t           new_ent;
  logic [1:0]        occ_q;
  logic              ready_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] res;
  logic              push;
  logic              pop;
  logic              head_match;
  logic              tail_match;

  // Load extension only applies to memory data; ALU results pass untouched.
  always_comb begin
    res = in_ans_alu;
    if (in_sel) begin
      case (in_ld_mode)
        2'b01:   res = DATA_W'($signed(in_ans_dm[7:0]));
        2'b10:   res = DATA_W'(in_ans_dm[7:0]);
        default: res = in_ans_dm;
      endcase
    end
  end

  assign new_ent = '{rd: in_rd, dat: res};

  // ready_q keeps in_ready low until the first edge after reset release.
  assign in_ready = ready_q && (occ_q != 2'd2);
  assign push     = in_valid && in_ready && in_wen && (in_rd != '0);
  assign rf_wen   = (occ_q != 2'd0);
  assign pop      = rf_wen && rf_ready;
  assign rf_addr  = rf_wen ? head_q.rd  : '0;
  assign rf_wdata = rf_wen ? head_q.dat : '0;
  assign retire_count = cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= 2'd0;
      ready_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ready_q <= 1'b1;
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) head_q <= new_ent;
          else               tail_q <= new_ent;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          occ_q  <= occ_q - 2'd1;
        end
        // Push needs occ<2 and pop needs occ>0, so both together only happen at occ==1.
        2'b11:   head_q <= new_ent;
        default: ;
      endcase
      if (pop) cnt_q <= cnt_q + 1'b1;
    end
  end

  // The tail is the newer entry and only valid at occupancy 2.
  assign head_match = (occ_q != 2'd0) && (head_q.rd == fwd_rd);
  assign tail_match = (occ_q == 2'd2) && (tail_q.rd == fwd_rd);

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_rd != '0) begin
      if (tail_match) begin
        fwd_hit  = 1'b1;
        fwd_data = tail_q.dat;
      end else if (head_match) begin
        fwd_hit  = 1'b1;
        fwd_data = head_q.dat;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe; CNT_W is narrowed so counter wrap is reachable quickly.
module tb_wb_stage_pipe;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic              in_wen;
  logic [ADDR_W-1:0] in_rd;
  logic              in_sel;
  logic [1:0]        in_ld_mode;
  logic [DATA_W-1:0] in_ans_alu;
  logic [DATA_W-1:0] in_ans_dm;
  logic              rf_wen;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_ready;
  logic [ADDR_W-1:0] fwd_rd;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [CNT_W-1:0]  retire_count;

  int n_cmp = 0;
  int n_err = 0;

  wb_stage_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen), .in_rd(in_rd),
    .in_sel(in_sel), .in_ld_mode(in_ld_mode), .in_ans_alu(in_ans_alu), .in_ans_dm(in_ans_dm),
    .rf_wen(rf_wen), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
    .fwd_rd(fwd_rd), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .retire_count(retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wen, input logic [ADDR_W-1:0] rd, input logic sel,
                       input logic [1:0] mode, input logic [DATA_W-1:0] alu,
                       input logic [DATA_W-1:0] dm);
    in_valid   = 1'b1;
    in_wen     = wen;
    in_rd      = rd;
    in_sel     = sel;
    in_ld_mode = mode;
    in_ans_alu = alu;
    in_ans_dm  = dm;
  endtask

  // Accept one entry into an empty buffer, check the write it presents, then let it commit.
  task automatic load_case(input string tag, input logic sel, input logic [1:0] mode,
                           input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] dm,
                           input logic [DATA_W-1:0] exp);
    drive(1'b1, 3'd6, sel, mode, alu, dm);
    tick();
    in_valid = 1'b0;
    chk(tag, rf_wdata, exp);
    tick();
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_wen = 1'b0; in_rd = '0; in_sel = 1'b0;
    in_ld_mode = 2'b00; in_ans_alu = '0; in_ans_dm = '0; rf_ready = 1'b0; fwd_rd = '0;

    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rf_wen", rf_wen, 0);
    chk("rst_rf_addr", rf_addr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_fwd_hit", fwd_hit, 0);
    chk("rst_fwd_data", fwd_data, 0);
    chk("rst_retire", retire_count, 0);

    #19 reset = 1'b1;
    chk("pre_edge_in_ready", in_ready, 0);
    tick();
    chk("post_rel_in_ready", in_ready, 1);

    // Basic ALU write
    rf_ready = 1'b1;
    drive(1'b1, 3'd3, 1'b0, 2'b00, 16'h1234, 16'h0000);
    tick();
    in_valid = 1'b0;
    chk("basic_rf_wen", rf_wen, 1);
    chk("basic_rf_addr", rf_addr, 3);
    chk("basic_rf_wdata", rf_wdata, 16'h1234);
    chk("basic_retire_pre", retire_count, 0);
    tick();
    chk("basic_retire", retire_count, 1);
    chk("basic_rf_wen_off", rf_wen, 0);

    // Load extension
    load_case("ld_sb_f5", 1'b1, 2'b01, 16'h0000, 16'h00F5, 16'hFFF5);
    load_case("ld_ub_f5", 1'b1, 2'b10, 16'h0000, 16'h00F5, 16'h00F5);
    load_case("ld_full_f5", 1'b1, 2'b00, 16'h0000, 16'h00F5, 16'h00F5);
    load_case("ld_sb_ab80", 1'b1, 2'b01, 16'h0000, 16'hAB80, 16'hFF80);
    load_case("ld_full11_ab80", 1'b1, 2'b11, 16'h0000, 16'hAB80, 16'hAB80);
    load_case("alu_ignores_mode", 1'b0, 2'b01, 16'h00F5, 16'hAB80, 16'h00F5);
    chk("ld_retire", retire_count, 7);

    // Back-pressure
    rf_ready = 1'b0;
    drive(1'b1, 3'd1, 1'b0, 2'b00, 16'h0101, 16'h0000);
    tick();
    chk("bp_ready_occ1", in_ready, 1);
    drive(1'b1, 3'd2, 1'b0, 2'b00, 16'h0202, 16'h0000);
    tick();
    chk("bp_ready_full", in_ready, 0);
    chk("bp_head_addr", rf_addr, 1);
    drive(1'b1, 3'd4, 1'b0, 2'b00, 16'h0404, 16'h0000);
    tick();
    chk("bp_still_full", in_ready, 0);
    chk("bp_stable_addr", rf_addr, 1);
    chk("bp_stable_data", rf_wdata, 16'h0101);
    rf_ready = 1'b1;
    #1 chk("bp_no_passthru", in_ready, 0);
    tick();
    chk("bp_commit1_addr", rf_addr, 2);
    chk("bp_commit1_cnt", retire_count, 8);
    chk("bp_ready_again", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_swap_addr", rf_addr, 4);
    chk("bp_swap_data", rf_wdata, 16'h0404);
    chk("bp_swap_cnt", retire_count, 9);
    tick();
    chk("bp_done_cnt", retire_count, 10);
    chk("bp_done_wen", rf_wen, 0);

    // Discard
    drive(1'b0, 3'd5, 1'b0, 2'b00, 16'h5555, 16'h0000);
    tick();
    chk("disc_wen0", rf_wen, 0);
    drive(1'b1, 3'd0, 1'b0, 2'b00, 16'h6666, 16'h0000);
    tick();
    in_valid = 1'b0;
    chk("disc_rd0", rf_wen, 0);
    tick();
    chk("disc_cnt", retire_count, 10);

    // Forwarding
    rf_ready = 1'b0;
    fwd_rd = 3'd2;
    drive(1'b1, 3'd2, 1'b0, 2'b00, 16'h0011, 16'h0000);
    #1 chk("fwd_not_visible", fwd_hit, 0);
    tick();
    chk("fwd_one_hit", fwd_hit, 1);
    chk("fwd_one_data", fwd_data, 16'h0011);
    drive(1'b1, 3'd2, 1'b0, 2'b00, 16'h0022, 16'h0000);
    tick();
    in_valid = 1'b0;
    #1;
    chk("fwd_newest_hit", fwd_hit, 1);
    chk("fwd_newest_data", fwd_data, 16'h0022);
    chk("fwd_head_data", rf_wdata, 16'h0011);
    fwd_rd = 3'd0;
    #1 chk("fwd_rd0_hit", fwd_hit, 0);
    chk("fwd_rd0_data", fwd_data, 0);
    fwd_rd = 3'd7;
    #1 chk("fwd_rd7_hit", fwd_hit, 0);
    fwd_rd = 3'd2;

    // Async reset with two pending
    reset = 1'b0;
    #1;
    chk("arst_rf_wen", rf_wen, 0);
    chk("arst_cnt", retire_count, 0);
    chk("arst_fwd_hit", fwd_hit, 0);
    chk("arst_in_ready", in_ready, 0);
    reset = 1'b1;
    tick();
    chk("arst_rel_ready", in_ready, 1);
    chk("arst_rel_wen", rf_wen, 0);

    // Full-rate streaming and counter wrap
    rf_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 3'd5, 1'b0, 2'b00, 16'(16'h0A00 + i), 16'h0000);
      tick();
      if (i == 3 || i == 9) begin
        chk("stream_data", rf_wdata, 32'(16'h0A00 + i));
        chk("stream_cnt", retire_count, i);
      end
    end
    in_valid = 1'b0;
    chk("wrap_cnt0", retire_count, 0);
    chk("wrap_wen", rf_wen, 1);
    tick();
    chk("wrap_cnt1", retire_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_stage_pipe.md
# wb_stage_pipe

Parametrised write-back stage for the pipelined MIPS datapath, successor to the single-register 16-bit write-back latch. It takes completed instructions from the data-memory stage under a valid/ready handshake, selects the ALU or memory result, and applies load byte-extension. Results are held in a 2-entry FIFO until the register file accepts the write. It also provides a newest-first forwarding lookup over pending writes and a retired-write counter.

## Interface
- DATA_W, 16, datapath/result width (≥8)
- ADDR_W, 3, register index width; register 0 is hardwired zero
- CNT_W, 16, width of retire counter
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept an entry this cycle
- in_wen  in  1  instruction writes a register
- in_rd  in  ADDR_W  destination register
- in_sel  in  1  0 = ALU result, 1 = memory data
- in_ld_mode  in  2  00 full, 01 signed byte, 10 unsigned byte, 11 full
- in_ans_alu  in  DATA_W  ALU result
- in_ans_dm  in  DATA_W  data-memory read data
- rf_wen  out  1  write request to register file
- rf_addr  out  ADDR_W  write address
- rf_wdata  out  DATA_W  write data
- rf_ready  in  1  register file accepts write this cycle
- fwd_rd  in  ADDR_W  forwarding query register
- fwd_hit  out  1  a pending write targets fwd_rd
- fwd_data  out  DATA_W  data of newest matching pending write
- retire_count  out  CNT_W  number of committed writes, wraps

## Operation
- Accept: in_valid && in_ready at a rising edge.
- Result formation at accept:
  - Select: in_sel=0 → in_ans_alu; in_sel=1 → in_ans_dm.
  - Extension (in_sel=1 only): 01 sign-extends bits [7:0]; 10 zero-extends bits [7:0]; 00/11 pass the full word.
  - With in_sel=0, in_ld_mode is ignored.
- Discard: an accepted entry with in_wen=0 or in_rd=0 is consumed and not buffered. It produces no write and no count.
- Buffer: 2-entry FIFO of {rd, data}; occupancy 0..2.
- in_ready = (occupancy < 2). There is no same-cycle pass-through when full: in_ready stays 0 at occupancy 2, even while rf_ready=1.
- Output: rf_wen = (occupancy > 0); rf_addr/rf_wdata = head entry.
- Commit: rf_wen && rf_ready at an edge pops the head and increments retire_count (mod 2^CNT_W).
- Simultaneous accept and commit at occupancy 1: the new entry becomes the head; occupancy stays 1.
- Forwarding (combinational):
  - fwd_hit = 1 if any valid entry has rd == fwd_rd and fwd_rd != 0.
  - fwd_data = the tail (newest) match if both entries match, else the single match, else 0.

## Timing
- Reset asserted (reset=0): occupancy 0; outputs in_ready=0, rf_wen=0, rf_addr=0, rf_wdata=0, fwd_hit=0, fwd_data=0, retire_count=0.
- First edge after release: in_ready=1.
- Reset mid-operation drops all pending entries immediately, asynchronously.
- Latency: an entry accepted at edge N drives rf_wen=1 in the cycle after edge N, provided the FIFO was empty. If the FIFO was occupied, it waits behind the head.
- Throughput: 1 write/cycle while rf_ready=1.
- rf_addr/rf_wdata stay stable while rf_wen=1 and rf_ready=0.
- Forwarding reflects buffer contents registered at the last edge. The entry being accepted in the current cycle is not visible.
- retire_count wraps from 2^CNT_W−1 to 0.

## Test plan
- Reset, then accept {wen=1, rd=3, sel=0, alu=0x1234} with rf_ready=1 → rf_wen=1, rf_addr=3, rf_wdata=0x1234 one cycle later; retire_count=1 after the next edge.
- Load extension: sel=1, dm=0x00F5:
  - mode 01 → 0xFFF5
  - mode 10 → 0x00F5
  - mode 00 → 0x00F5
  - dm=0xAB80, mode 01 → 0xFF80
- Back-pressure: rf_ready=0, offer 3 entries to rd 1, 2, 4 → the first two are accepted and in_ready=0. Raise rf_ready → writes 1, 2, 4 commit in order; retire_count=3.
- Discard: wen=0, rd=5 and wen=1, rd=0 → both accepted, rf_wen never asserts, retire_count unchanged.
- Forwarding: rf_ready=0, buffer rd=2/0x0011 then rd=2/0x0022:
  - fwd_rd=2 → fwd_hit=1, fwd_data=0x0022
  - fwd_rd=0 → fwd_hit=0
  - fwd_rd=7 → fwd_hit=0
- Async reset pulse with 2 entries pending → rf_wen=0 and retire_count=0 without a clock edge; in_ready=1 after release.
